// File: rtl/jk_onoff_fsm.sv
// Two-state Moore on/off latch: j turns it on, k turns it off, both high toggles.
// dout is decoded straight from the single state flop, so it never depends on j or k combinationally.
module jk_onoff_fsm (
   input  logic clk,
   input  logic areset,
   input  logic j,
   input  logic k,
   output logic dout
);

   typedef enum logic {
      OFF = 1'b0,
      ON  = 1'b1
   } state_t;

   state_t state_reg;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_reg <= OFF;
      end else begin
         case (state_reg)
            OFF:     if (j) state_reg <= ON;
            ON:      if (k) state_reg <= OFF;
            default: state_reg <= OFF;
         endcase
      end
   end

   assign dout = (state_reg == ON);

endmodule

// File: tb/tb_jk_onoff_fsm.sv
// Directed vector table, async-reset corner sequence and a random soak against a two-state model.
module tb_jk_onoff_fsm;

   logic clk = 1'b0;
   logic areset = 1'b1;
   logic j = 1'b0;
   logic k = 1'b0;
   logic dout;

   int n_checks = 0;
   int n_fail = 0;

   jk_onoff_fsm dut (
      .clk    (clk),
      .areset (areset),
      .j      (j),
      .k      (k),
      .dout   (dout)
   );

   always #5 clk = ~clk;

   typedef struct {
      string tag;
      logic  rst;
      logic  kk;
      logic  jj;
      logic  exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: dout=%b expected=%b at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input string tag, input logic rst, input logic kk, input logic jj, input logic exp);
      vec_t v;
      v.tag = tag;
      v.rst = rst;
      v.kk = kk;
      v.jj = jj;
      v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic run_table();
      foreach (vecs[i]) begin
         @(negedge clk);
         areset = vecs[i].rst;
         k = vecs[i].kk;
         j = vecs[i].jj;
         @(posedge clk);
         #1;
         $display("vec %0d %s: areset=%b k=%b j=%b dout=%b exp=%b",
                  i, vecs[i].tag, vecs[i].rst, vecs[i].kk, vecs[i].jj, dout, vecs[i].exp);
         check(vecs[i].tag, dout, vecs[i].exp);
      end
      vecs.delete();
   endtask

   logic model;
   logic [3:0] seq_kj [12];
   logic       seq_exp [12];

   initial begin
      // Power-up and release
      add("pwr_reset", 1, 0, 0, 0);
      add("pwr_on",    0, 0, 1, 1);
      add("pwr_hold",  0, 0, 0, 1);
      run_table();

      // Async reset mid-cycle while ON
      @(negedge clk);
      k = 0; j = 0;
      areset = 1;
      #1;
      check("async_drop", dout, 1'b0);
      @(posedge clk);
      #1;
      check("async_hold_edge", dout, 1'b0);
      @(negedge clk);
      areset = 0;
      #1;
      check("async_release", dout, 1'b0);
      @(posedge clk);
      #1;
      check("async_post_edge", dout, 1'b0);

      // Directed {k,j} sequence from OFF
      seq_kj  = '{4'b00, 4'b01, 4'b01, 4'b01, 4'b00, 4'b10, 4'b10, 4'b11, 4'b11, 4'b11, 4'b11, 4'b11};
      seq_exp = '{0, 1, 1, 1, 1, 0, 0, 1, 0, 1, 0, 1};
      for (int i = 0; i < 12; i++)
         add($sformatf("seq%0d", i), 0, seq_kj[i][1], seq_kj[i][0], seq_exp[i]);
      // Ignore opposite input (sequence ends ON, so turn off first)
      add("to_off",    0, 1, 0, 0);
      for (int i = 0; i < 3; i++) add("off_ign_k", 0, 1, 0, 0);
      add("to_on",     0, 0, 1, 1);
      for (int i = 0; i < 3; i++) add("on_ign_j",  0, 0, 1, 1);
      // Reset dominance
      for (int i = 0; i < 3; i++) add("rst_dom",   1, 0, 1, 0);
      add("rst_release", 0, 0, 1, 1);
      run_table();

      // Random soak: inputs change on both edges, reset pulses asserted at falling edges
      model = dout;
      for (int c = 0; c < 150; c++) begin
         @(negedge clk);
         areset = ($urandom_range(7) == 0);
         j = 1'($urandom_range(1));
         k = 1'($urandom_range(1));
         if (areset) model = 1'b0;
         #1;
         check("soak_neg", dout, model);
         @(posedge clk);
         if (areset)      model = 1'b0;
         else if (!model) model = j;
         else             model = ~k;
         #1;
         check("soak_pos", dout, model);
         j = 1'($urandom_range(1));
         k = 1'($urandom_range(1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
